// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RESET    = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_WB_R     = 4'd4,
      ST_EXEC_I   = 4'd5,
      ST_WB_I     = 4'd6,
      ST_MEM_ADDR = 4'd7,
      ST_MEM_ACC  = 4'd8,
      ST_WB_MEM   = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JAL      = 4'd11,
      ST_JR       = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_ANDI = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_ADDI = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_LW   = 4'b1000;
   localparam logic [3:0] ALU_SW   = 4'b1001;
   localparam logic [3:0] ALU_BEQ  = 4'b1010;
   localparam logic [3:0] ALU_JAL  = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_JR   = 4'b1111;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] SRCB_REGB    = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_ctrl;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
   } ctrl_t;

   typedef struct packed {
      logic       legal;
      logic [3:0] op;
   } r_op_t;

   function automatic logic opcode_legal(input logic [5:0] opcode);
      case (opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_BEQ, OP_JAL: return 1'b1;
         default:                                                  return 1'b0;
      endcase
   endfunction

   function automatic r_op_t r_alu_op(input logic [5:0] funct);
      case (funct)
         FN_ADD:  return '{legal: 1'b1, op: ALU_ADD};
         FN_SLL:  return '{legal: 1'b1, op: ALU_SLL};
         FN_AND:  return '{legal: 1'b1, op: ALU_AND};
         FN_NOR:  return '{legal: 1'b1, op: ALU_NOR};
         FN_SLT:  return '{legal: 1'b1, op: ALU_SLT};
         default: return '{legal: 1'b0, op: ALU_JR};
      endcase
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - combinational control-word decode from state and IR fields
module ctrl_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       alu_zero_i,
   input  logic       mem_ready_i,
   input  logic       req_drop_i,
   output ctrl_t      ctrl_o,
   output logic       illegal_now_o
);

   r_op_t r_op;

   always_comb begin
      ctrl_o        = '0;
      illegal_now_o = 1'b0;
      r_op          = r_alu_op(funct_i);

      case (state_i)
         ST_FETCH: begin
            // req_drop_i marks the single idle cycle that follows a bus timeout
            ctrl_o.mem_req   = ~req_drop_i;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_ctrl  = ALU_ADD;
            if (mem_ready_i && !req_drop_i) begin
               ctrl_o.ir_write = 1'b1;
               ctrl_o.pc_write = 1'b1;
               ctrl_o.pc_src   = PC_SRC_ALU;
            end
         end
         ST_DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_ctrl  = ALU_ADD;
            illegal_now_o    = ~opcode_legal(opcode_i);
         end
         ST_EXEC_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REGB;
            ctrl_o.alu_ctrl  = r_op.op;
            illegal_now_o    = ~r_op.legal;
         end
         ST_WB_R: begin
            ctrl_o.reg_write  = r_op.legal;
            ctrl_o.reg_dst    = REGDST_RD;
            ctrl_o.mem_to_reg = M2R_ALUOUT;
         end
         ST_EXEC_I: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_ctrl  = (opcode_i == OP_ANDI) ? ALU_ANDI : ALU_ADDI;
         end
         ST_WB_I: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = REGDST_RT;
            ctrl_o.mem_to_reg = M2R_ALUOUT;
         end
         ST_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_ctrl  = (opcode_i == OP_SW) ? ALU_SW : ALU_LW;
         end
         ST_MEM_ACC: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.iord    = 1'b1;
            ctrl_o.mem_we  = (opcode_i == OP_SW);
         end
         ST_WB_MEM: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = REGDST_RT;
            ctrl_o.mem_to_reg = M2R_MDR;
         end
         ST_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REGB;
            ctrl_o.alu_ctrl  = ALU_BEQ;
            ctrl_o.pc_src    = PC_SRC_ALUOUT;
            ctrl_o.pc_write  = alu_zero_i;
         end
         ST_JAL: begin
            // PC already holds PC+4 from FETCH, so it is the link value
            ctrl_o.alu_ctrl   = ALU_JAL;
            ctrl_o.pc_src     = PC_SRC_JUMP;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = REGDST_RA;
            ctrl_o.mem_to_reg = M2R_PC;
         end
         ST_JR: begin
            ctrl_o.alu_ctrl = ALU_JR;
            ctrl_o.pc_src   = PC_SRC_RS;
            ctrl_o.pc_write = 1'b1;
         end
         default: begin
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control FSM with memory-handshake timeout
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int ALU_W       = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [ALU_W-1:0] alu_ctrl,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             illegal,
   output logic             bus_err,
   output logic [3:0]       state_o
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_q, drop_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             waiting;
   logic             timeout_hit;
   logic             illegal_now;
   ctrl_t            ctrl;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         drop_q    <= 1'b0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // A cycle counts toward the timeout only while a request is actually outstanding
   always_comb begin
      waiting     = ((state_q == ST_FETCH && !drop_q) || state_q == ST_MEM_ACC) && !mem_ready;
      timeout_hit = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CNT_LAST);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            if (timeout_hit)
               state_d = ST_FETCH;
            else if (mem_ready && !drop_q)
               state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:       state_d = (funct == FN_JR) ? ST_JR : ST_EXEC_R;
               OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
               OP_ADDI, OP_ANDI: state_d = ST_EXEC_I;
               OP_BEQ:         state_d = ST_BRANCH;
               OP_JAL:         state_d = ST_JAL;
               default:        state_d = ST_FETCH;
            endcase
         end
         ST_EXEC_R:   state_d = ST_WB_R;
         ST_EXEC_I:   state_d = ST_WB_I;
         ST_MEM_ADDR: state_d = ST_MEM_ACC;
         ST_MEM_ACC: begin
            if (timeout_hit)
               state_d = ST_FETCH;
            else if (mem_ready)
               state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB_MEM;
         end
         ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JR: state_d = ST_FETCH;
         default:     state_d = ST_RESET;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (timeout_hit || state_d != state_q)
         cnt_d = '0;
      else if (waiting && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
      drop_d    = timeout_hit;
      illegal_d = illegal_q | illegal_now;
      bus_err_d = bus_err_q | timeout_hit;
   end

   ctrl_output_decode u_decode (
      .state_i       (state_q),
      .opcode_i      (opcode),
      .funct_i       (funct),
      .alu_zero_i    (alu_zero),
      .mem_ready_i   (mem_ready),
      .req_drop_i    (drop_q),
      .ctrl_o        (ctrl),
      .illegal_now_o (illegal_now)
   );

   always_comb begin
      pc_write   = ctrl.pc_write;
      pc_src     = ctrl.pc_src;
      ir_write   = ctrl.ir_write;
      mem_req    = ctrl.mem_req;
      mem_we     = ctrl.mem_we;
      iord       = ctrl.iord;
      alu_src_a  = ctrl.alu_src_a;
      alu_src_b  = ctrl.alu_src_b;
      alu_ctrl   = ALU_W'(ctrl.alu_ctrl);
      reg_write  = ctrl.reg_write;
      reg_dst    = ctrl.reg_dst;
      mem_to_reg = ctrl.mem_to_reg;
      illegal    = illegal_q | illegal_now;
      bus_err    = bus_err_q;
      state_o    = state_q;
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       alu_zero;
   logic       mem_ready;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctrl;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       illegal;
   logic       bus_err;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;
   logic [24:0] exp_v;
   logic [24:0] got_v;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.ALU_W(4), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
      .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err),
      .state_o(state_o)
   );

   assign got_v = {state_o, pc_write, pc_src, ir_write, mem_req, mem_we, iord, alu_src_a,
                   alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal, bus_err};

   // expected word: state, then every output in port order
   function automatic logic [24:0] cv(input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
                                      input logic irw, input logic mreq, input logic mwe,
                                      input logic io, input logic sa, input logic [1:0] sb,
                                      input logic [3:0] alu, input logic rw, input logic [1:0] rd,
                                      input logic [1:0] m2r, input logic ill, input logic be);
      return {st, pcw, pcs, irw, mreq, mwe, io, sa, sb, alu, rw, rd, m2r, ill, be};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
      step(); step(); #1;
      exp_v = '0;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL reset_held got %h exp %h", got_v, exp_v); end
      rst_n = 1'b1; #1;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL reset_release got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd1, 0, 2'd0, 0, 1, 0, 0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL reset_to_fetch got %h exp %h", got_v, exp_v); end
   endtask

   task automatic test_add();
      opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; #1;
      exp_v = cv(4'd1, 1, 2'd0, 1, 1, 0, 0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL add_fetch got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 4'b0010, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL add_decode got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd3, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 4'b0010, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL add_exec got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd4, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 4'b0000, 1, 2'd1, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL add_wb got %h exp %h", got_v, exp_v); end
      step(); #1;
      checks++;
      if (state_o !== 4'd1) begin errors++; $display("FAIL add_back_fetch got %0d exp 1", state_o); end
   endtask

   task automatic test_lw_wait();
      opcode = 6'b100011; mem_ready = 1'b1;
      step(); #1;
      checks++;
      if (state_o !== 4'd2) begin errors++; $display("FAIL lw_decode got %0d exp 2", state_o); end
      step(); #1;
      exp_v = cv(4'd7, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 4'b1000, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL lw_addr got %h exp %h", got_v, exp_v); end
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         exp_v = cv(4'd8, 0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 2'd0, 0, 0);
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL lw_acc_%0d got %h exp %h", i, got_v, exp_v); end
         if (i == 3) mem_ready = 1'b1;
      end
      step(); #1;
      exp_v = cv(4'd9, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 4'b0000, 1, 2'd0, 2'd1, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL lw_wb got %h exp %h", got_v, exp_v); end
      step(); #1;
      checks++;
      if (state_o !== 4'd1) begin errors++; $display("FAIL lw_back_fetch got %0d exp 1", state_o); end
   endtask

   task automatic test_beq();
      opcode = 6'b000100; alu_zero = 1'b1;
      step(); step(); #1;
      exp_v = cv(4'd10, 1, 2'd1, 0, 0, 0, 0, 1, 2'd0, 4'b1010, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL beq_taken got %h exp %h", got_v, exp_v); end
      step(); #1;
      checks++;
      if (state_o !== 4'd1) begin errors++; $display("FAIL beq_back_fetch got %0d exp 1", state_o); end
      alu_zero = 1'b0;
      step(); step(); #1;
      exp_v = cv(4'd10, 0, 2'd1, 0, 0, 0, 0, 1, 2'd0, 4'b1010, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL beq_not_taken got %h exp %h", got_v, exp_v); end
      step();
   endtask

   task automatic test_jal_jr();
      opcode = 6'b000011;
      step(); step(); #1;
      exp_v = cv(4'd11, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 4'b1011, 1, 2'd2, 2'd2, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL jal got %h exp %h", got_v, exp_v); end
      step();
      opcode = 6'b000000; funct = 6'b001000;
      step(); step(); #1;
      exp_v = cv(4'd12, 1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 0, 2'd0, 2'd0, 0, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL jr got %h exp %h", got_v, exp_v); end
      step(); #1;
      checks++;
      if (state_o !== 4'd1) begin errors++; $display("FAIL jr_back_fetch got %0d exp 1", state_o); end
   endtask

   task automatic test_illegal();
      opcode = 6'b111111;
      step(); #1;
      exp_v = cv(4'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 4'b0010, 0, 2'd0, 2'd0, 1, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL ill_decode got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd1, 1, 2'd0, 1, 1, 0, 0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0, 1, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL ill_fetch got %h exp %h", got_v, exp_v); end
      opcode = 6'b000000; funct = 6'b000010;
      step(); step(); #1;
      exp_v = cv(4'd3, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 4'b1111, 0, 2'd0, 2'd0, 1, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL badfn_exec got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd4, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 4'b0000, 0, 2'd1, 2'd0, 1, 0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL badfn_wb got %h exp %h", got_v, exp_v); end
      step(); #1;
      checks++;
      if (illegal !== 1'b1 || state_o !== 4'd1) begin
         errors++; $display("FAIL ill_sticky got %b/%0d exp 1/1", illegal, state_o);
      end
   endtask

   task automatic test_timeout_and_abort();
      rst_n = 1'b0; mem_ready = 1'b0;
      step(); #1;
      checks++;
      if (got_v !== 25'd0) begin errors++; $display("FAIL rst_clears_flags got %h exp 0", got_v); end
      rst_n = 1'b1;
      step(); #1;
      for (int i = 1; i <= 15; i++) begin
         exp_v = cv(4'd1, 0, 2'd0, 0, 1, 0, 0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0, 0, 0);
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL to_wait_%0d got %h exp %h", i, got_v, exp_v); end
         step(); #1;
      end
      exp_v = cv(4'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0, 0, 1);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL to_drop got %h exp %h", got_v, exp_v); end
      step(); #1;
      exp_v = cv(4'd1, 0, 2'd0, 0, 1, 0, 0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0, 0, 1);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL to_rereq got %h exp %h", got_v, exp_v); end
      opcode = 6'b101011; mem_ready = 1'b1;
      step(); step(); #1;
      exp_v = cv(4'd7, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 4'b1001, 0, 2'd0, 2'd0, 0, 1);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL sw_addr got %h exp %h", got_v, exp_v); end
      mem_ready = 1'b0;
      step(); #1;
      exp_v = cv(4'd8, 0, 2'd0, 0, 1, 1, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 2'd0, 0, 1);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL sw_acc got %h exp %h", got_v, exp_v); end
      rst_n = 1'b0;
      step(); #1;
      checks++;
      if (got_v !== 25'd0) begin errors++; $display("FAIL abort_reset got %h exp 0", got_v); end
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_beq();
      test_jal_jr();
      test_illegal();
      test_timeout_and_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
